// File: rtl/mcmem_pkg.sv
// Shared definitions for the multicycle memory responder: FSM state
// encoding, default geometry/latency and the data word width.
package mcmem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage : mcmem_pkg

// File: rtl/mcmem_array.sv
// Word storage for mcmem_resp: synchronous write and synchronous read,
// sharing one index port. Only the read-data register is reset; the
// storage array itself keeps its contents across reset.
import mcmem_pkg::*;

module mcmem_array #(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic                           rd_clr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_reg;

  // Storage write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read data; holds between reads, rd_clr loads zero instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (rd_en) begin
      rdata_reg <= rd_clr ? '0 : mem[idx];
    end
  end

  assign rdata = rdata_reg;

endmodule : mcmem_array

// File: rtl/mcmem_resp.sv
// Multicycle memory responder: accepts one request in IDLE, waits
// WAIT_CYCLES in BUSY, performs the access on the edge entering RESP and
// pulses ready for one cycle.
// Optional feature: define MCMEM_ALIGN_CHECK_EN to flag misaligned
// accesses (write suppressed, rdata forced to zero, err raised).
import mcmem_pkg::*;

module mcmem_resp #(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [AW-1:0]     idx_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic              mis_reg;

  logic              accept;
  logic              access;
  logic              mis_in;
  logic              eff_we;
  logic              eff_mis;
  logic [AW-1:0]     eff_idx;
  logic [WORD_W-1:0] eff_wdata;
  logic              unused_addr_bits;

  assign accept = (state_reg == IDLE) && req;

`ifdef MCMEM_ALIGN_CHECK_EN
  assign mis_in = (addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  // Upper address bits wrap away; byte-offset bits only matter for the check.
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // With zero wait states the access happens on the accepting edge itself,
  // so in IDLE the array sees the live inputs rather than the latches.
  assign eff_we    = (state_reg == IDLE) ? we            : we_reg;
  assign eff_idx   = (state_reg == IDLE) ? addr[AW+1:2]  : idx_reg;
  assign eff_wdata = (state_reg == IDLE) ? wdata         : wdata_reg;
  assign eff_mis   = (state_reg == IDLE) ? mis_in        : mis_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> BUSY/RESP on req, BUSY -> RESP at count 1,
  // RESP always back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = (WAIT_CYCLES > 0) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
    end else if (accept) begin
      cnt_reg <= WAIT_INIT;
    end else if (state_reg == BUSY) begin
      cnt_reg <= cnt_reg - 4'd1;
    end else begin
      cnt_reg <= 4'd0;
    end
  end

  // Request latches: captured only on the accepting edge, ignored otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      mis_reg   <= 1'b0;
    end else if (accept) begin
      we_reg    <= we;
      idx_reg   <= addr[AW+1:2];
      wdata_reg <= wdata;
      mis_reg   <= mis_in;
    end
  end

  // The access is performed on the edge that enters RESP.
  assign access = (state_next == RESP);

  mcmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (access && eff_we && !eff_mis),
    .rd_en (access && (!eff_we || eff_mis)),
    .rd_clr(eff_mis),
    .idx   (eff_idx),
    .wdata (eff_wdata),
    .rdata (rdata)
  );

  assign ready = (state_reg == RESP);

`ifdef MCMEM_ALIGN_CHECK_EN
  assign err = ready && mis_reg;
`else
  assign err = 1'b0;
`endif

endmodule : mcmem_resp

// File: doc/mcmem_resp.md
MCMEM_RESP -- requirements
Module: mcmem_resp

Interface
- REQ-001: The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words stored; it is a power of two, and AW = log2(DEPTH_WORDS).
- REQ-002: The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving the number of wait states before a response.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: req  input  1  access request from the multicycle controller datapath; held high until ready.
- REQ-006: we  input  1  1 = write, 0 = read; sampled with req.
- REQ-007: addr  input  32  byte address; word index = addr[AW+1:2].
- REQ-008: wdata  input  32  write data; sampled with req.
- REQ-009: rdata  output  32  registered read data; valid while ready = 1.
- REQ-010: ready  output  1  one-cycle completion pulse.
- REQ-011: err  output  1  misaligned-access flag; valid while ready = 1.

Function
- REQ-012: The FSM SHALL have three states: IDLE, BUSY, RESP.
- REQ-013: In IDLE, req = 1 at a rising edge (edge E) SHALL accept the request and latch we, addr and wdata.
  - The 4-bit counter SHALL load WAIT_CYCLES.
  - The next state SHALL be BUSY if WAIT_CYCLES > 0, else RESP.
- REQ-014: In BUSY, each edge SHALL decrement the counter; the edge at which the counter equals 1 SHALL move the FSM to RESP.
- REQ-015: The edge entering RESP SHALL perform the access on the latched values.
  - Write: mem[index] <= wdata.
  - Read: rdata <= mem[index].
- REQ-016: ready SHALL be 1 exactly in the cycle following edge E+WAIT_CYCLES, i.e. only while in RESP, and 0 in all other cycles.
- REQ-017: RESP SHALL return to IDLE unconditionally, so back-to-back requests are separated by at least one IDLE cycle.
- REQ-018: req, we, addr and wdata changes while in BUSY or RESP SHALL be ignored, with no re-latch.
- REQ-019: Address bits above AW+1 SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
- REQ-020: rdata SHALL hold its last value after a write response and through IDLE/BUSY; it changes only at the edge entering RESP for a read.
- REQ-021: A read followed by a write to the same word, then a read of that word, SHALL return the new data, with no stale bypass issue.

Reset
- REQ-022: rst = 1 SHALL force state = IDLE, counter = 0, ready = 0, err = 0 and rdata = 32'h0 immediately, independent of clk.
- REQ-023: rst asserted during BUSY SHALL discard the pending access: no write is performed and no ready is issued.
- REQ-024: Memory array contents SHALL NOT be affected by reset.

Configuration
- REQ-025: With macro MCMEM_ALIGN_CHECK_EN defined, a latched addr[1:0] != 0 at the edge entering RESP SHALL suppress any write, set rdata = 32'h0 and set err = 1 for that RESP cycle.
- REQ-026: With MCMEM_ALIGN_CHECK_EN undefined, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Structure
- REQ-027: Package mcmem_pkg SHALL hold the state encoding (IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10), the default DEPTH_WORDS and WAIT_CYCLES, and the word width constant (32).
- REQ-028: The storage SHALL be sub-module mcmem_array, a synchronous-write, synchronous-read word array with a write-enable and one shared index port.
- REQ-029: mcmem_resp SHALL contain only the FSM, the counter, the latches and the alignment check.

Verification
- REQ-030: The bench SHALL cover the following directed scenarios.
  - WAIT_CYCLES = 2: write 32'hDEADBEEF to addr 32'h10, then read 32'h10 -> ready exactly 2 cycles after each accepting edge, rdata = 32'hDEADBEEF, err = 0.
  - WAIT_CYCLES = 0: read accepted at edge E -> ready high in the cycle after E, single-cycle pulse.
  - DEPTH_WORDS = 1024: write 32'h1 to addr 32'h0000_1004, then read addr 32'h4 -> rdata = 32'h1 (wrap).
  - rst pulsed while BUSY during a write of 32'h55 to 32'h20 -> no ready, and a later read of 32'h20 returns the prior value; rdata = 0 right after reset.
  - With MCMEM_ALIGN_CHECK_EN: write to 32'h22 -> ready with err = 1 and rdata = 0, and mem[8] is unchanged; without the macro the same write stores to word 8 with err = 0.
  - Change addr and wdata while BUSY -> the originally latched values are used; req held high through RESP -> the next request is accepted only after the IDLE cycle.
